clock_time_counter: RTL and testbench

Parametrised BCD time-of-day counter that generates the hour/minute/second digits consumed by `LT24Top` (`valueHr1`…`valueMin0`) and adds seconds digits. It supports a load/set port with range checking and an update strobe handshaked against display readiness. The block sits between the system clock and the LT24 display top level. Its update strobe is gated by `displayReady` (driven from `~resetApp`), so the display never receives digits before initialisation completes.

---
 rtl/clock_time_counter.sv | 226 ++++++++++++++++++++++
 tb/tb_clock_time_counter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// BCD time-of-day counter (HH:MM:SS) with range-checked load and a display update handshake.
// Optional feature macro: TWELVE_HOUR_EN selects 12 h mode with a PM flag; undefined builds a 24 h counter.
module clock_time_counter #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int SIM_DIVIDE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       displayReady,
  input  logic       setLoad,
  input  logic [3:0] setHr1,
  input  logic [3:0] setHr0,
  input  logic [3:0] setMin1,
  input  logic [3:0] setMin0,
  input  logic [3:0] setSec1,
  input  logic [3:0] setSec0,
  input  logic       setPm,
  output logic [3:0] valueHr1,
  output logic [3:0] valueHr0,
  output logic [3:0] valueMin1,
  output logic [3:0] valueMin0,
  output logic [3:0] valueSec1,
  output logic [3:0] valueSec0,
  output logic       pm,
  output logic       secondTick,
  output logic       update,
  output logic       setError
);

  localparam int TICK_CYCLES = CLOCK_FREQ / SIM_DIVIDE;
  localparam int PRESC_W     = $clog2(TICK_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

`ifdef TWELVE_HOUR_EN
  localparam logic [3:0] RST_HR1 = 4'd1;
  localparam logic [3:0] RST_HR0 = 4'd2;
`else
  localparam logic [3:0] RST_HR1 = 4'd0;
  localparam logic [3:0] RST_HR0 = 4'd0;
`endif

  function automatic logic valid_min_sec(input logic [3:0] d1, input logic [3:0] d0);
    return (d1 <= 4'd5) && (d0 <= 4'd9);
  endfunction

  function automatic logic valid_hours(input logic [3:0] h1, input logic [3:0] h0);
`ifdef TWELVE_HOUR_EN
    return ((h1 == 4'd0) && (h0 != 4'd0) && (h0 <= 4'd9)) || ((h1 == 4'd1) && (h0 <= 4'd2));
`else
    return ((h1 <= 4'd1) && (h0 <= 4'd9)) || ((h1 == 4'd2) && (h0 <= 4'd3));
`endif
  endfunction

  logic [PRESC_W-1:0] presc_r, presc_nxt_s;
  logic [3:0] hr1_r, hr0_r, min1_r, min0_r, sec1_r, sec0_r;
  logic [3:0] inc_hr1_s, inc_hr0_s, inc_min1_s, inc_min0_s, inc_sec1_s, inc_sec0_s;
  logic [3:0] nxt_hr1_s, nxt_hr0_s, nxt_min1_s, nxt_min0_s, nxt_sec1_s, nxt_sec0_s;
  logic       carry_sec1_s, carry_min0_s, carry_min1_s, carry_hr_s;
  logic       tick_s, load_valid_s, load_ok_s, load_err_s;
  logic       pm_chg_s, change_s;
  logic       pending_r, second_tick_r, update_r, set_error_r;

  assign tick_s       = run && (presc_r == PRESC_LAST);
  assign load_valid_s = valid_hours(setHr1, setHr0) && valid_min_sec(setMin1, setMin0)
                        && valid_min_sec(setSec1, setSec0);
  assign load_ok_s    = setLoad && load_valid_s;
  assign load_err_s   = setLoad && !load_valid_s;

  // Ripple carries through the six digits, all resolved within one cycle.
  assign carry_sec1_s = (sec0_r == 4'd9);
  assign carry_min0_s = carry_sec1_s && (sec1_r == 4'd5);
  assign carry_min1_s = carry_min0_s && (min0_r == 4'd9);
  assign carry_hr_s   = carry_min1_s && (min1_r == 4'd5);

  assign inc_sec0_s = carry_sec1_s ? 4'd0 : sec0_r + 4'd1;
  assign inc_sec1_s = !carry_sec1_s ? sec1_r : ((sec1_r == 4'd5) ? 4'd0 : sec1_r + 4'd1);
  assign inc_min0_s = !carry_min0_s ? min0_r : ((min0_r == 4'd9) ? 4'd0 : min0_r + 4'd1);
  assign inc_min1_s = !carry_min1_s ? min1_r : ((min1_r == 4'd5) ? 4'd0 : min1_r + 4'd1);

`ifdef TWELVE_HOUR_EN
  logic pm_r, inc_pm_s, nxt_pm_s;

  // Hour roll in 12 h mode: 11 -> 12 flips AM/PM, 12 -> 01 keeps it.
  always_comb begin
    inc_hr1_s = hr1_r;
    inc_hr0_s = hr0_r;
    inc_pm_s  = pm_r;
    if (!carry_hr_s) begin
      inc_hr1_s = hr1_r;
    end else if ((hr1_r == 4'd1) && (hr0_r == 4'd1)) begin
      inc_hr0_s = 4'd2;
      inc_pm_s  = !pm_r;
    end else if ((hr1_r == 4'd1) && (hr0_r == 4'd2)) begin
      inc_hr1_s = 4'd0;
      inc_hr0_s = 4'd1;
    end else if (hr0_r == 4'd9) begin
      inc_hr1_s = 4'd1;
      inc_hr0_s = 4'd0;
    end else begin
      inc_hr0_s = hr0_r + 4'd1;
    end
  end

  // PM flag follows a valid load, otherwise the tick.
  always_comb begin
    nxt_pm_s = pm_r;
    if (load_ok_s) begin
      nxt_pm_s = setPm;
    end else if (tick_s) begin
      nxt_pm_s = inc_pm_s;
    end else begin
      nxt_pm_s = pm_r;
    end
  end

  assign pm_chg_s = (nxt_pm_s != pm_r);
  assign pm       = pm_r;

  // PM flag register, present only in the 12 h build.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pm_r <= 1'b0;
    end else begin
      pm_r <= nxt_pm_s;
    end
  end
`else
  logic unused_pm_s;
  assign unused_pm_s = setPm;
  assign pm_chg_s    = 1'b0;
  assign pm          = 1'b0;

  // Hour roll in 24 h mode: 23 -> 00, x9 -> (x+1)0.
  always_comb begin
    inc_hr1_s = hr1_r;
    inc_hr0_s = hr0_r;
    if (!carry_hr_s) begin
      inc_hr1_s = hr1_r;
    end else if ((hr1_r == 4'd2) && (hr0_r == 4'd3)) begin
      inc_hr1_s = 4'd0;
      inc_hr0_s = 4'd0;
    end else if (hr0_r == 4'd9) begin
      inc_hr1_s = hr1_r + 4'd1;
      inc_hr0_s = 4'd0;
    end else begin
      inc_hr0_s = hr0_r + 4'd1;
    end
  end
`endif

  // Next digits and prescaler: a valid load beats a coincident tick.
  always_comb begin
    nxt_hr1_s   = hr1_r;
    nxt_hr0_s   = hr0_r;
    nxt_min1_s  = min1_r;
    nxt_min0_s  = min0_r;
    nxt_sec1_s  = sec1_r;
    nxt_sec0_s  = sec0_r;
    presc_nxt_s = presc_r;
    if (load_ok_s) begin
      nxt_hr1_s   = setHr1;
      nxt_hr0_s   = setHr0;
      nxt_min1_s  = setMin1;
      nxt_min0_s  = setMin0;
      nxt_sec1_s  = setSec1;
      nxt_sec0_s  = setSec0;
      presc_nxt_s = {PRESC_W{1'b0}};
    end else if (tick_s) begin
      nxt_hr1_s   = inc_hr1_s;
      nxt_hr0_s   = inc_hr0_s;
      nxt_min1_s  = inc_min1_s;
      nxt_min0_s  = inc_min0_s;
      nxt_sec1_s  = inc_sec1_s;
      nxt_sec0_s  = inc_sec0_s;
      presc_nxt_s = {PRESC_W{1'b0}};
    end else if (run) begin
      presc_nxt_s = presc_r + PRESC_W'(1);
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  assign change_s = ({nxt_hr1_s, nxt_hr0_s, nxt_min1_s, nxt_min0_s, nxt_sec1_s, nxt_sec0_s}
                     != {hr1_r, hr0_r, min1_r, min0_r, sec1_r, sec0_r}) || pm_chg_s;

  // Time state, strobes and redraw bookkeeping; pending starts set so the first ready cycle redraws.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_r       <= {PRESC_W{1'b0}};
      hr1_r         <= RST_HR1;
      hr0_r         <= RST_HR0;
      min1_r        <= 4'd0;
      min0_r        <= 4'd0;
      sec1_r        <= 4'd0;
      sec0_r        <= 4'd0;
      pending_r     <= 1'b1;
      second_tick_r <= 1'b0;
      update_r      <= 1'b0;
      set_error_r   <= 1'b0;
    end else begin
      presc_r       <= presc_nxt_s;
      hr1_r         <= nxt_hr1_s;
      hr0_r         <= nxt_hr0_s;
      min1_r        <= nxt_min1_s;
      min0_r        <= nxt_min0_s;
      sec1_r        <= nxt_sec1_s;
      sec0_r        <= nxt_sec0_s;
      pending_r     <= change_s || (pending_r && !displayReady);
      second_tick_r <= tick_s && !load_ok_s;
      update_r      <= pending_r && displayReady;
      set_error_r   <= load_err_s;
    end
  end

  assign valueHr1   = hr1_r;
  assign valueHr0   = hr0_r;
  assign valueMin1  = min1_r;
  assign valueMin0  = min0_r;
  assign valueSec1  = sec1_r;
  assign valueSec0  = sec0_r;
  assign secondTick = second_tick_r;
  assign update     = update_r;
  assign setError   = set_error_r;

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter: stimulus queues expected update/error/tick events, a monitor checks them.
module tb_clock_time_counter;

  logic clock = 1'b0;
  logic reset, run, displayReady, setLoad, setPm;
  logic [3:0] setHr1, setHr0, setMin1, setMin0, setSec1, setSec0;
  logic [3:0] valueHr1, valueHr0, valueMin1, valueMin0, valueSec1, valueSec0;
  logic pm, secondTick, update, setError;
  logic [23:0] dig_s;

  typedef struct {
    logic [23:0] d;
    logic        p;
    int          c;
  } exp_t;

  exp_t upd_q[$];
  exp_t err_q[$];
  int   tick_q[$];
  exp_t e;
  int   tc;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef TWELVE_HOUR_EN
  localparam logic [23:0] RST_D  = 24'h120000;
  localparam logic [23:0] LOAD_A = 24'h115958;
  localparam logic [23:0] A1     = 24'h115959;
  localparam logic [23:0] A2     = 24'h120000;
  localparam logic        A2_PM  = 1'b1;
`else
  localparam logic [23:0] RST_D  = 24'h000000;
  localparam logic [23:0] LOAD_A = 24'h235958;
  localparam logic [23:0] A1     = 24'h235959;
  localparam logic [23:0] A2     = 24'h000000;
  localparam logic        A2_PM  = 1'b0;
`endif

  clock_time_counter #(.CLOCK_FREQ(50000000), .SIM_DIVIDE(5000000)) dut (
    .clock(clock), .reset(reset), .run(run), .displayReady(displayReady), .setLoad(setLoad),
    .setHr1(setHr1), .setHr0(setHr0), .setMin1(setMin1), .setMin0(setMin0),
    .setSec1(setSec1), .setSec0(setSec0), .setPm(setPm),
    .valueHr1(valueHr1), .valueHr0(valueHr0), .valueMin1(valueMin1), .valueMin0(valueMin0),
    .valueSec1(valueSec1), .valueSec0(valueSec0), .pm(pm),
    .secondTick(secondTick), .update(update), .setError(setError)
  );

  assign dig_s = {valueHr1, valueHr0, valueMin1, valueMin0, valueSec1, valueSec0};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic xpm(input logic p);
`ifdef TWELVE_HOUR_EN
    return p;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every strobe the DUT raises must match the head of its queue.
  always @(negedge clock) begin
    if (update === 1'b1) begin
      checks++;
      if (upd_q.size() == 0) begin
        errors++;
        $display("FAIL update_unexpected cycle %0d digits %h pm %b", cyc, dig_s, pm);
      end else begin
        e = upd_q.pop_front();
        if (dig_s !== e.d || pm !== e.p || cyc != e.c) begin
          errors++;
          $display("FAIL update got %h pm %b cycle %0d expected %h pm %b cycle %0d",
                   dig_s, pm, cyc, e.d, e.p, e.c);
        end
      end
    end
    if (setError === 1'b1) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL set_error_unexpected cycle %0d digits %h", cyc, dig_s);
      end else begin
        e = err_q.pop_front();
        if (dig_s !== e.d || pm !== e.p || cyc != e.c) begin
          errors++;
          $display("FAIL set_error got %h pm %b cycle %0d expected %h pm %b cycle %0d",
                   dig_s, pm, cyc, e.d, e.p, e.c);
        end
      end
    end
    if (secondTick === 1'b1) begin
      checks++;
      if (tick_q.size() == 0) begin
        errors++;
        $display("FAIL second_tick_unexpected cycle %0d", cyc);
      end else begin
        tc = tick_q.pop_front();
        if (cyc != tc) begin
          errors++;
          $display("FAIL second_tick got cycle %0d expected cycle %0d", cyc, tc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // kind: 0 = no strobe, 1 = update expected, 2 = setError expected
  task automatic do_load(input logic [23:0] d, input logic p, input int kind,
                         input logic [23:0] ed, input logic ep);
    int c;
    exp_t x;
    c = cyc;
    {setHr1, setHr0, setMin1, setMin0, setSec1, setSec0} = d;
    setPm   = p;
    setLoad = 1'b1;
    x.d = ed;
    x.p = ep;
    if (kind == 1) begin
      x.c = c + 2;
      upd_q.push_back(x);
    end else if (kind == 2) begin
      x.c = c + 1;
      err_q.push_back(x);
    end
    @(posedge clock);
    #1;
    setLoad = 1'b0;
  endtask

  task automatic push_upd(input logic [23:0] d, input logic p, input int c);
    exp_t x;
    x.d = d;
    x.p = p;
    x.c = c;
    upd_q.push_back(x);
  endtask

  task automatic tick_test(input logic [23:0] start, input logic sp,
                           input logic [23:0] expd, input logic ep);
    int f;
    do_load(start, sp, 1, start, xpm(sp));
    f = cyc;
    run = 1'b1;
    tick_q.push_back(f + 10);
    push_upd(expd, xpm(ep), f + 11);
    wait_until(f + 12);
    run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, q, ev, g;
    reset = 1'b0;
    run = 1'b0;
    displayReady = 1'b0;
    setLoad = 1'b0;
    setPm = 1'b0;
    {setHr1, setHr0, setMin1, setMin0, setSec1, setSec0} = 24'h000000;
    repeat (3) @(posedge clock);
    #1;
    check("reset_digits", {8'h00, dig_s}, {8'h00, RST_D});
    check("reset_strobes", {28'h0, pm, secondTick, update, setError}, 32'h0);

    // Release reset with the display not ready; one update once it becomes ready.
    reset = 1'b1;
    wait_until(cyc + 50);
    q = cyc;
    push_upd(RST_D, 1'b0, q + 1);
    displayReady = 1'b1;
    wait_until(q + 3);

    // Roll over midnight (24 h) or into PM noon (12 h) with two ticks.
    do_load(LOAD_A, 1'b0, 1, LOAD_A, 1'b0);
    d = cyc;
    run = 1'b1;
    tick_q.push_back(d + 10);
    push_upd(A1, 1'b0, d + 11);
    tick_q.push_back(d + 20);
    push_upd(A2, A2_PM, d + 21);

    // Load coincides with the third terminal count: tick discarded, prescaler restarts.
    wait_until(d + 29);
    do_load(24'h123456, 1'b1, 1, 24'h123456, xpm(1'b1));
    tick_q.push_back(d + 40);
    push_upd(24'h123457, xpm(1'b1), d + 41);

    // Three ticks while the display is not ready collapse into one update.
    wait_until(d + 42);
    displayReady = 1'b0;
    tick_q.push_back(d + 50);
    tick_q.push_back(d + 60);
    tick_q.push_back(d + 70);
    wait_until(d + 72);
    push_upd(24'h123500, xpm(1'b1), d + 73);
    displayReady = 1'b1;

    // Freeze mid-second; the held count resumes without loss.
    wait_until(d + 75);
    run = 1'b0;
    wait_until(d + 95);
    ev = cyc;
    run = 1'b1;
    tick_q.push_back(ev + 5);
    push_upd(24'h123501, xpm(1'b1), ev + 6);
    wait_until(ev + 8);
    run = 1'b0;

    // Rejected loads leave everything unchanged.
    do_load(24'h090F00, 1'b0, 2, 24'h123501, xpm(1'b1));
    wait_until(cyc + 2);
    do_load(24'h240000, 1'b0, 2, 24'h123501, xpm(1'b1));
    wait_until(cyc + 2);
    do_load(24'h120060, 1'b0, 2, 24'h123501, xpm(1'b1));
    wait_until(cyc + 2);
    check("after_rejects", {8'h00, dig_s}, 32'h00123501);

    // Hour digit carries.
    tick_test(24'h095959, 1'b0, 24'h100000, 1'b0);
`ifdef TWELVE_HOUR_EN
    tick_test(24'h125959, 1'b1, 24'h010000, 1'b1);
`else
    tick_test(24'h195959, 1'b0, 24'h200000, 1'b0);
`endif

    // Asynchronous reset mid-operation forces a redraw on the first ready cycle.
    wait_until(cyc + 3);
    g = cyc;
    reset = 1'b0;
    #2;
    check("midop_reset_digits", {8'h00, dig_s}, {8'h00, RST_D});
    check("midop_reset_pm", {31'h0, pm}, 32'h0);
    wait_until(g + 2);
    push_upd(RST_D, 1'b0, g + 3);
    reset = 1'b1;
    wait_until(g + 10);

    check("update_queue_empty", upd_q.size(), 32'h0);
    check("error_queue_empty", err_q.size(), 32'h0);
    check("tick_queue_empty", tick_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
